// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one sum bit per clock through a two-half-adder slice
// and a carry flip-flop, with a start/busy/done handshake and held result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             load;
  logic             last;
  logic             half1_s;
  logic             half1_c;
  logic             half2_c;
  logic             s_bit;
  logic             carry_next;

  assign last = (count == CW'(WIDTH - 1));

  // Bit slice: two half adders on the LSBs and the carry, OR-merged carries.
  always_comb begin
    half1_s    = sa[0] ^ sb[0];
    half1_c    = sa[0] & sb[0];
    s_bit      = half1_s ^ carry;
    half2_c    = half1_s & carry;
    carry_next = half1_c | half2_c;
    res_next   = WIDTH'({s_bit, res} >> 1'b1);
  end

  // Next-state and operand-load decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        // A start in the completion cycle chains straight into the next run.
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Serial datapath: operand shifters, carry flop, result shifter and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      res   <= '0;
      carry <= cin;
      count <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1'b1;
      sb    <= sb >> 1'b1;
      res   <= res_next;
      carry <= carry_next;
      count <= count + CW'(1);
      if (last) begin
        sum  <= res_next;
        cout <= carry_next;
      end else begin
        sum  <= sum;
        cout <= cout;
      end
    end else begin
      sa    <= sa;
      sb    <= sb;
      res   <= res;
      carry <= carry;
      count <= count;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner-case sequences and
// a random sweep, all scored through an expected-result queue.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             co;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    int               edge_n;
  } exp_t;

  exp_t             sbq[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: scores each completion and checks the result stays held otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1) begin
      sbq.delete();
      held_sum  = '0;
      held_cout = 1'b0;
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.co});
        check("done_latency", cyc, e.edge_n);
        held_sum  = e.s;
        held_cout = e.co;
      end
    end else begin
      check("sum_held", {24'd0, sum}, {24'd0, held_sum});
      check("cout_held", {31'd0, cout}, {31'd0, held_cout});
    end
  end

  task automatic drive_start(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb, input logic opc);
    exp_t           e;
    logic [WIDTH:0] full;
    full     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, opc};
    start    = 1'b1;
    a        = opa;
    b        = opb;
    cin      = opc;
    e.s      = full[WIDTH-1:0];
    e.co     = full[WIDTH];
    e.edge_n = cyc + 1 + WIDTH;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string name, input int exp_busy);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * WIDTH && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) nb++;
        #1 start = 1'b0;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb, input logic opc);
    @(negedge clk);
    #1 drive_start(opa, opb, opc);
    wait_done(name, WIDTH);
  endtask

  vec_t vecs[8];
  int   ndone;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_op("vec", vecs[i].a, vecs[i].b, vecs[i].cin);
      check("vec_sum", {24'd0, sum}, {24'd0, vecs[i].s});
      check("vec_cout", {31'd0, cout}, {31'd0, vecs[i].co});
    end

    // start and operand changes during RUN must be ignored
    @(negedge clk);
    #1 drive_start(8'h10, 8'h20, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1 start = 1'b0;
    end
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b1;
    wait_done("ignore_start", WIDTH - 3);
    check("ignore_sum", {24'd0, sum}, 32'h30);
    ndone = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("ignore_single_done", ndone, 0);
    check("ignore_idle_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a run aborts it and clears the result
    @(negedge clk);
    #1 drive_start(8'h0F, 8'h01, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1 start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    ndone = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op("after_abort", 8'h0F, 8'h01, 1'b0);
    check("after_abort_sum", {24'd0, sum}, 32'h10);

    // back-to-back: start held during the done cycle
    run_op("b2b_first", 8'h01, 8'h02, 1'b0);
    check("b2b_first_sum", {24'd0, sum}, 32'h03);
    check("b2b_first_cout", {31'd0, cout}, 32'd0);
    #1 drive_start(8'h80, 8'h80, 1'b0);
    wait_done("b2b_second", WIDTH);
    check("b2b_second_sum", {24'd0, sum}, 32'h00);
    check("b2b_second_cout", {31'd0, cout}, 32'd1);

    // random sweep against the queued reference results
    for (int i = 0; i < 1000; i++) begin
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1, 0)));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that consumes one sum/carry bit-slice per clock.
- Each slice is built from two half-adder stages (XOR/AND) plus an OR, feeding a carry flip-flop.
- Sits downstream of the half-adder cell; used wherever area matters more than latency.
- Start/done handshake to the controlling logic; result and carry-out are registered and held.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when the block is not busy
a  input  WIDTH  operand A; sampled only on an accepted start
b  input  WIDTH  operand B; sampled only on an accepted start
cin  input  1  carry-in; sampled only on an accepted start
busy  output  1  high while the addition is in progress (RUN state)
done  output  1  single-cycle completion pulse
sum  output  WIDTH  registered result; held until the next completion
cout  output  1  registered carry-out (unsigned overflow); held with sum

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter cleared.
  - rst has priority over start.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- Accepting a start (IDLE or DONE, start=1 at edge k):
  - Load shift registers SA<=a and SB<=b; carry<=cin; count<=0; state<=RUN.
- RUN, each edge:
  - s = SA[0]^SB[0]^carry.
  - carry <= (SA[0]&SB[0]) | (carry&(SA[0]^SB[0])).
  - SA and SB shift right by 1.
  - s shifts into the internal result register at the MSB, shifting right.
  - count <= count+1.
  - When count==WIDTH-1, the same edge also does sum<=final result, cout<=final carry, state<=DONE.
- Latency:
  - Start accepted at edge k; WIDTH processing edges k+1..k+WIDTH.
  - done=1 during the cycle after edge k+WIDTH, for exactly one cycle.
  - busy=1 from edge k through edge k+WIDTH-1 inclusive (WIDTH cycles).
- DONE:
  - start=1 at the next edge: treated as an accepted start (back-to-back; goes straight to RUN).
  - Otherwise returns to IDLE.
- start while in RUN: ignored, with no effect on the current operation and no queuing.
- Operand changes on a, b or cin during RUN: ignored.
- sum/cout change only at a completion edge or on reset; intermediate partial sums are never visible on sum.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no saturation.
- Reset mid-RUN:
  - Aborts the operation; no done pulse is produced.
  - sum/cout are cleared to 0, not left at the previous result.
- WIDTH=1: one RUN cycle; done appears at edge k+1.
- Counter width: clog2(WIDTH)+1 bits; count must not wrap before WIDTH-1 is reached.

Test Plan:
- WIDTH=8, reset, then start with a=0x5A, b=0x3C, cin=0 -> busy high 8 cycles; done pulses once at edge k+8; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start a=0x10, b=0x20; at cycle 3 of RUN pulse start with a=0xAA and change a/b -> ignored; result 0x30, cout=0; only one done pulse.
- Start a=0x0F, b=0x01; assert rst at cycle 4 of RUN -> busy=0, done never pulses, sum=0x00, cout=0, state IDLE; a new start afterwards completes normally.
- Back-to-back: first start 0x01+0x02; hold start=1 with a=0x80, b=0x80 during the done cycle -> first result 0x03/0; second run begins immediately; 8 cycles later sum=0x00, cout=1; 0x03 is held on sum until then.
- Random sweep: 1000 random a/b/cin, reference model {cout,sum}=a+b+cin -> every completion matches; each done exactly WIDTH cycles after its accepted start.
